// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - UART receive and instruction-memory write signals of the program loader
//
// Signal names carry the loader's point of view (_i into the loader, _o out of it).
//   rx_received_i  one-cycle pulse: rx_data_i holds a received byte
//   rx_data_i      received byte
//   mem_we_o       one-cycle word write strobe
//   mem_addr_o     word address
//   mem_wdata_o    write data
// master: the loader. slave: the UART engine / instruction memory side.
interface uart_program_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_received_i;
  logic [7:0]            rx_data_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;

  modport master (
    input  rx_received_i, rx_data_i,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output rx_received_i, rx_data_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - assembles UART bytes into 32-bit words and writes them to instruction memory
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   programmer_mode_i   high requests a programming session
//   bus (master)        UART byte input and memory write port
//   core_rst_o          holds the CPU in reset during a session and RELEASE_CYCLES after it
//   busy_o              high outside IDLE
//   done_o              one-cycle pulse when the loader returns to IDLE
//   overflow_o          sticky per session: a word arrived after the last address was written
//   word_count_o        words written in the current/last session (saturates at 2^ADDR_WIDTH)
module uart_program_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  programmer_mode_i,
  uart_program_loader_if.master bus,
  output logic                  core_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FLUSH, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [RW-1:0]         rel_q, rel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;     // last address has been written this session

  logic [31:0] ins_buf;    // buffer with the incoming byte placed at idx
  logic [1:0]  ins_idx;    // idx after accepting the incoming byte (if any)
  logic        start_wr;   // entering WRITE or FLUSH this cycle
  logic [31:0] wr_word;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      rel_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      rel_q      <= rel_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    tmo_d      = tmo_q;
    rel_d      = rel_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    core_rst_d = core_rst_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    count_d    = count_q;
    full_d     = full_q;
    start_wr   = 1'b0;
    wr_word    = buf_q;
    ins_buf    = buf_q;
    ins_idx    = idx_q;
    if (bus.rx_received_i) begin
      ins_buf[{idx_q, 3'b000} +: 8] = bus.rx_data_i;
      ins_idx = idx_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (programmer_mode_i) begin
          state_d    = RECV;
          addr_d     = '0;
          idx_d      = '0;
          buf_d      = '0;
          tmo_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          full_d     = 1'b0;
          core_rst_d = 1'b1;
        end
      end

      RECV: begin
        buf_d = ins_buf;
        idx_d = ins_idx;
        if (bus.rx_received_i) begin
          tmo_d = '0;
        end else if (idx_q != 2'd0) begin
          tmo_d = tmo_q + TW'(1);
        end
        if (bus.rx_received_i && idx_q == 2'd3) begin
          state_d  = WRITE;
          start_wr = 1'b1;
          wr_word  = ins_buf;
          buf_d    = '0;
          idx_d    = '0;
        end else if (!programmer_mode_i ||
                     (!bus.rx_received_i && idx_q != 2'd0 && tmo_q == TMO_LAST)) begin
          // Exit decision uses idx after any byte accepted this cycle.
          if (ins_idx != 2'd0) begin
            state_d  = FLUSH;
            start_wr = 1'b1;
            wr_word  = ins_buf;   // upper bytes are still zero from the last clear
            buf_d    = '0;
            idx_d    = '0;
            tmo_d    = '0;
          end else begin
            state_d = RELEASE;
            rel_d   = '0;
          end
        end
      end

      WRITE, FLUSH: begin
        tmo_d = '0;
        // Bookkeeping follows the strobe; a suppressed (overflow) write changes nothing.
        if (we_q) begin
          count_d = count_q + 1'b1;
          if (addr_q == '1) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        if (state_q == WRITE || programmer_mode_i) begin
          state_d = RECV;
          if (bus.rx_received_i) begin
            buf_d = {24'd0, bus.rx_data_i};
            idx_d = 2'd1;
          end
        end else begin
          state_d = RELEASE;
          rel_d   = '0;
        end
      end

      RELEASE: begin
        if (rel_q == REL_LAST) begin
          state_d    = IDLE;
          core_rst_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          rel_d = rel_q + RW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_wr) begin
      wdata_d    = wr_word;
      we_d       = !full_q;
      overflow_d = overflow_q | full_q;
    end
  end

  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign core_rst_o      = core_rst_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign overflow_o      = overflow_q;
  assign word_count_o    = count_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader
module tb_uart_program_loader;
  localparam int AW  = 2;
  localparam int TMO = 100;
  localparam int REL = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          mode;
  logic          core_rst, busy, done, ovf;
  logic [AW:0]   wcnt;

  int total = 0;
  int bad   = 0;

  uart_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_program_loader #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .RELEASE_CYCLES(REL)
  ) dut (
    .aclk(aclk), .areset(areset), .programmer_mode_i(mode), .bus(bus),
    .core_rst_o(core_rst), .busy_o(busy), .done_o(done),
    .overflow_o(ovf), .word_count_o(wcnt)
  );

  always #5 aclk = ~aclk;

  // Observed memory writes
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  always @(negedge aclk) begin
    if (bus.mem_we_o === 1'b1) begin
      obs_addr.push_back(int'(bus.mem_addr_o));
      obs_data.push_back(bus.mem_wdata_o);
    end
  end

  // Reference model: bytes pack little-endian into words; word n goes to address n
  // while n < 2^AW, later words are dropped and flag overflow.
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          part[$];
  int          nwords;
  bit          ovf_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < part.size(); i++) w = w + (32'(part[i]) << (8 * i));
    if (nwords < (1 << AW)) begin
      exp_addr.push_back(nwords);
      exp_data.push_back(w);
    end else begin
      ovf_exp = 1'b1;
    end
    nwords++;
    part.delete();
  endtask

  task automatic model_byte(input int b);
    part.push_back(b);
    if (part.size() == 4) emit();
  endtask

  task automatic model_flush();
    if (part.size() > 0) emit();
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit drop);
    bus.rx_received_i = 1'b1;
    bus.rx_data_i     = b;
    if (drop) mode = 1'b0;
    tick();
    bus.rx_received_i = 1'b0;
    model_byte(int'(b));
  endtask

  task automatic start_session();
    nwords  = 0;
    ovf_exp = 1'b0;
    part.delete();
    exp_addr.delete();
    exp_data.delete();
    obs_addr.delete();
    obs_data.delete();
    mode = 1'b1;
    tick();
    chk("start_core_rst", core_rst, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_overflow", ovf, 1'b0);
    chk("start_count", 32'(wcnt), 32'd0);
  endtask

  // k0: ticks already taken since mode=0 was first sampled; lat: expected tick of core release.
  task automatic finish_session(input int k0, input int lat);
    int k;
    int n;
    k = k0;
    model_flush();
    while (core_rst === 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk("release_latency", 32'(k), 32'(lat));
    chk("done_pulse", done, 1'b1);
    chk("busy_idle", busy, 1'b0);
    chk("word_count", 32'(wcnt), 32'((nwords < (1 << AW)) ? nwords : (1 << AW)));
    chk("overflow", ovf, ovf_exp);
    tick();
    chk("done_single", done, 1'b0);
    chk("n_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 32'(obs_addr[i]), 32'(exp_addr[i]));
      chk("wr_data", obs_data[i], exp_data[i]);
    end
  endtask

  bit early;
  int waited;
  int nb;
  bit simul;

  initial begin
    areset = 1'b1;
    mode   = 1'b0;
    bus.rx_received_i = 1'b0;
    bus.rx_data_i     = 8'd0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_core_rst", core_rst, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", ovf, 1'b0);
    chk("rst_count", 32'(wcnt), 32'd0);
    chk("rst_we", bus.mem_we_o, 1'b0);
    chk("rst_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    areset = 1'b0;

    // Bytes in IDLE are ignored
    for (int i = 0; i < 6; i++) begin
      bus.rx_received_i = 1'b1;
      bus.rx_data_i     = 8'($urandom);
      tick();
    end
    bus.rx_received_i = 1'b0;
    idle(3);
    chk("idle_no_write", 32'(obs_addr.size()), 32'd0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_core_rst", core_rst, 1'b0);

    // Full session with two words
    start_session();
    send(8'h13, 0); idle(1); send(8'h00, 0); idle(1);
    send(8'h00, 0); idle(1); send(8'h00, 0); idle(1);
    send(8'h93, 0); idle(1); send(8'h00, 0); idle(1);
    send(8'h10, 0); idle(1); send(8'h00, 0); idle(2);
    mode = 1'b0;
    finish_session(0, REL + 1);

    // Partial word flushed on mode fall
    start_session();
    send(8'hAA, 0); send(8'hBB, 0); idle(2);
    mode = 1'b0;
    finish_session(0, REL + 2);

    // Timeout flush of a single byte, following word lands at addr 1
    start_session();
    send(8'h11, 0);
    early = 1'b0;
    for (int i = 0; i < TMO - 5; i++) begin
      tick();
      if (bus.mem_we_o === 1'b1) early = 1'b1;
    end
    chk("tmo_not_early", early, 1'b0);
    waited = 0;
    while (bus.mem_we_o !== 1'b1 && waited < 30) begin
      tick();
      waited++;
    end
    chk("tmo_flush_we", bus.mem_we_o, 1'b1);
    chk("tmo_flush_data", bus.mem_wdata_o, 32'h0000_0011);
    model_flush();
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    idle(2);
    mode = 1'b0;
    finish_session(0, REL + 1);

    // Back-to-back bytes; strobe one cycle after each 4th byte
    start_session();
    for (int i = 0; i < 8; i++) begin
      bus.rx_received_i = 1'b1;
      bus.rx_data_i     = 8'($urandom);
      model_byte(int'(bus.rx_data_i));
      tick();
      if (i == 3 || i == 7) begin
        chk("b2b_we", bus.mem_we_o, 1'b1);
        chk("b2b_addr", 32'(bus.mem_addr_o), 32'(exp_addr[exp_addr.size() - 1]));
        chk("b2b_data", bus.mem_wdata_o, exp_data[exp_data.size() - 1]);
      end
    end
    bus.rx_received_i = 1'b0;
    idle(2);
    mode = 1'b0;
    finish_session(0, REL + 1);

    // Overflow: five words into a four-word memory
    start_session();
    for (int i = 0; i < 20; i++) send(8'($urandom), 0);
    idle(2);
    mode = 1'b0;
    finish_session(0, REL + 1);

    // New session clears overflow (checked in start_session), then reset mid-session
    start_session();
    send(8'h5A, 0);
    send(8'hA5, 0);
    #2;
    areset = 1'b1;
    #1;
    chk("abort_core_rst", core_rst, 1'b0);
    chk("abort_busy", busy, 1'b0);
    mode = 1'b0;
    idle(2);
    areset = 1'b0;
    idle(3);
    chk("abort_no_write", 32'(obs_addr.size()), 32'd0);
    chk("abort_count", 32'(wcnt), 32'd0);

    // Randomized sessions, some dropping mode together with the last byte
    for (int s = 0; s < 5; s++) begin
      nb = 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
      if (nb == 0) nb = 1;
      simul = 1'($urandom_range(0, 1));
      start_session();
      for (int i = 0; i < nb; i++) begin
        idle($urandom_range(0, 2));
        send(8'($urandom), simul && (i == nb - 1));
      end
      if (simul) begin
        finish_session(1, (nb % 4 != 0) ? REL + 2 : REL + 3);
      end else begin
        idle(2);
        mode = 1'b0;
        finish_session(0, (nb % 4 != 0) ? REL + 2 : REL + 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
